ifmap_stream_writer: RTL and testbench

- Producer end of the tagged IFMap stream that the Processing_element consumes through its IFMap circular_buffer.
- Reads feature-map rows from a synchronous-read scratch memory and writes words {tag[1:0], data[DATA_WIDTH-1:0]} into the FIFO write port.
- Tags: 2'b10 = first word of a row, 2'b00 = middle word, 2'b01 = last word of a row, 2'b11 = single-word row.
- Obeys FIFO backpressure: it writes only while the FIFO's ready (not full) output is high.

---
 rtl/ifmap_stream_writer_if.sv | 23 ++
 rtl/ifmap_stream_writer.sv | 167 ++++++++++++++++
 tb/tb_ifmap_stream_writer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifmap_stream_writer_if.sv
// Memory read port and tagged FIFO write port of the IFMap stream writer.
// master = writer side, slave = memory/FIFO side.
interface ifmap_stream_writer_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  fifo_ready;
  logic                  fifo_wen;
  logic [DATA_WIDTH+1:0] fifo_din;

  modport master (
    output mem_ren, mem_addr, fifo_wen, fifo_din,
    input  mem_rdata, fifo_ready
  );

  modport slave (
    input  mem_ren, mem_addr, fifo_wen, fifo_din,
    output mem_rdata, fifo_ready
  );
endinterface

// File: rtl/ifmap_stream_writer.sv
// Streams feature-map rows from scratch memory into the tagged IFMap FIFO via a 2-entry skid buffer.
// Optional zero padding around each row is enabled with `define IFMAP_WRITER_ZERO_PAD_EN.
module ifmap_stream_writer #(
  parameter int DATA_WIDTH    = 10,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_LEN_WIDTH = 6,
  parameter int ROW_CNT_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH-1:0]    base_addr_i,
  input  logic [ROW_LEN_WIDTH-1:0] row_len_i,
  input  logic [ROW_CNT_WIDTH-1:0] row_count_i,
  input  logic [ADDR_WIDTH-1:0]    row_stride_i,
`ifdef IFMAP_WRITER_ZERO_PAD_EN
  input  logic [1:0]               pad_i,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  ifmap_stream_writer_if.master    bus
);

  localparam int CW = ROW_LEN_WIDTH + 2;
  localparam int TW = CW + ROW_CNT_WIDTH;
  localparam int WW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                   state_q;
  logic                     busy_q, done_q;
  logic [ADDR_WIDTH-1:0]    rowptr_q, stride_q;
  logic [ROW_LEN_WIDTH-1:0] rowLen_q;
  logic [CW-1:0]            col_q;
  logic [TW-1:0]            issueLeft_q, writeLeft_q;
  logic                     inflight_q;
  logic [1:0]               inflightTag_q;
  logic [WW-1:0]            ent0_q, ent1_q, ent0_d, ent1_d;
  logic [1:0]               occ_q, occ_d;

  logic [CW-1:0]            rowWords, dataCol;
  logic [TW-1:0]            startTotal;
  logic                     padWord, pop, canIssue, push;
  logic [1:0]               curTag;
  logic [2:0]               occSum, occLimit;
  logic [WW-1:0]            pushWord;

`ifdef IFMAP_WRITER_ZERO_PAD_EN
  logic [1:0]               pad_q;
  logic [CW-1:0]            padW;

  // Emitted row = pad zeros, row_len pixels, pad zeros; col_q walks the emitted row.
  assign padW       = CW'(pad_q);
  assign rowWords   = CW'(rowLen_q) + (padW << 1);
  assign padWord    = (col_q < padW) || (col_q >= padW + CW'(rowLen_q));
  assign dataCol    = col_q - padW;
  assign startTotal = (row_len_i == '0 || row_count_i == '0) ? '0 :
                      TW'(row_count_i) * (TW'(row_len_i) + TW'({pad_i, 1'b0}));
`else
  assign rowWords   = CW'(rowLen_q);
  assign padWord    = 1'b0;
  assign dataCol    = col_q;
  assign startTotal = (row_len_i == '0 || row_count_i == '0) ? '0 :
                      TW'(row_count_i) * TW'(row_len_i);
`endif

  assign pop      = bus.fifo_ready && (occ_q != 2'd0);
  assign curTag   = {col_q == '0, col_q == rowWords - CW'(1)};
  assign occSum   = {1'b0, occ_q} + {2'b00, inflight_q};
  assign occLimit = 3'd1 + {2'b00, pop};

  // A pad word bypasses memory, so it waits until no read is in flight to keep order.
  assign canIssue = (state_q == RUN) && (issueLeft_q != '0) && (occSum <= occLimit) &&
                    !(padWord && inflight_q);

  assign bus.mem_ren  = canIssue && !padWord;
  assign bus.mem_addr = rowptr_q + ADDR_WIDTH'(dataCol);
  assign bus.fifo_wen = pop;
  assign bus.fifo_din = ent0_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  assign push     = inflight_q || (canIssue && padWord);
  assign pushWord = inflight_q ? {inflightTag_q, bus.mem_rdata} : {curTag, {DATA_WIDTH{1'b0}}};

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) ent0_d = pushWord;
      else               ent1_d = pushWord;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rowptr_q      <= '0;
      stride_q      <= '0;
      rowLen_q      <= '0;
      col_q         <= '0;
      issueLeft_q   <= '0;
      writeLeft_q   <= '0;
      inflight_q    <= 1'b0;
      inflightTag_q <= 2'b00;
      ent0_q        <= '0;
      ent1_q        <= '0;
      occ_q         <= 2'd0;
`ifdef IFMAP_WRITER_ZERO_PAD_EN
      pad_q         <= 2'b00;
`endif
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      occ_q      <= occ_d;
      inflight_q <= bus.mem_ren;
      if (bus.mem_ren) inflightTag_q <= curTag;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rowptr_q    <= base_addr_i;
            stride_q    <= row_stride_i;
            rowLen_q    <= row_len_i;
            col_q       <= '0;
            issueLeft_q <= startTotal;
            writeLeft_q <= startTotal;
`ifdef IFMAP_WRITER_ZERO_PAD_EN
            pad_q       <= pad_i;
`endif
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (canIssue) begin
            issueLeft_q <= issueLeft_q - TW'(1);
            if (col_q == rowWords - CW'(1)) begin
              col_q    <= '0;
              rowptr_q <= rowptr_q + stride_q;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
          if (pop) writeLeft_q <= writeLeft_q - TW'(1);
          // Zero-size jobs also pass through here so busy is seen for one cycle.
          if (writeLeft_q == '0 || (pop && writeLeft_q == TW'(1))) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Self-checking bench for ifmap_stream_writer: directed table plus random jobs checked against
// an arithmetic model of the tagged stream, with backpressure, reset and start-while-busy cases.
module tb_ifmap_stream_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] base_addr_i, row_stride_i;
  logic [5:0] row_len_i, row_count_i;
  logic [1:0] pad_i;
  logic       busy_o, done_o;

  int checks   = 0;
  int failures = 0;

  ifmap_stream_writer_if bus ();

  ifmap_stream_writer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .row_len_i    (row_len_i),
    .row_count_i  (row_count_i),
    .row_stride_i (row_stride_i),
`ifdef IFMAP_WRITER_ZERO_PAD_EN
    .pad_i        (pad_i),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read scratch memory: data appears the cycle after mem_ren.
  logic [9:0] memArr [256];
  always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= memArr[bus.mem_addr];

  typedef struct {
    int base, len, cnt, stride, pad, readyMode;
    int expWrites, expFirst, expDone, busyStartAt;
  } vec_t;

  vec_t         vecs[$];
  logic [11:0]  expWord[$];
  bit           expIsPad[$];
  int           expAddr[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected stream from the row/tag/padding rules, independent of how the DUT schedules it.
  task automatic buildModel(input vec_t v);
    int rw, a;
    expWord.delete(); expIsPad.delete(); expAddr.delete();
    if (v.len == 0 || v.cnt == 0) return;
    rw = v.len + 2 * v.pad;
    for (int r = 0; r < v.cnt; r++) begin
      for (int c = 0; c < rw; c++) begin
        logic [1:0] tag;
        tag = {c == 0, c == rw - 1};
        if (c < v.pad || c >= v.pad + v.len) begin
          expWord.push_back({tag, 10'd0});
          expIsPad.push_back(1'b1);
        end else begin
          a = (v.base + r * v.stride + c - v.pad) % 256;
          expAddr.push_back(a);
          expWord.push_back({tag, memArr[a]});
          expIsPad.push_back(1'b0);
        end
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int idx, writes, reads, dataWritten, lowLeft, firstIdx, doneIdx;
    bit finished, isPad;
    buildModel(v);
    @(negedge clk);
    base_addr_i  = 8'(v.base);
    row_len_i    = 6'(v.len);
    row_count_i  = 6'(v.cnt);
    row_stride_i = 8'(v.stride);
    pad_i        = 2'(v.pad);
    start_i      = 1'b1;
    @(posedge clk);
    idx = 0; writes = 0; reads = 0; dataWritten = 0; lowLeft = 3;
    firstIdx = -1; doneIdx = -1; finished = 0;
    while (!finished && idx < 2000) begin
      #1;
      case (v.readyMode)
        1: begin
          if (writes >= 2 && lowLeft > 0) begin bus.fifo_ready = 1'b0; lowLeft--; end
          else if (writes >= 2)             bus.fifo_ready = idx[0];
          else                              bus.fifo_ready = 1'b1;
        end
        2:       bus.fifo_ready = ($urandom_range(0, 3) != 0);
        default: bus.fifo_ready = 1'b1;
      endcase
      if (v.busyStartAt == idx) begin
        start_i = 1'b1; base_addr_i = 8'd100; row_len_i = 6'd3; row_count_i = 6'd1;
      end else begin
        start_i = 1'b0;
      end
      #1;
      checkOutput("wenWhileNotReady", 32'(bus.fifo_wen & ~bus.fifo_ready), 0);
      if (bus.mem_ren) begin
        reads++;
        if (expAddr.size() == 0) checkOutput("extraRead", 1, 0);
        else                     checkOutput("readAddr", 32'(bus.mem_addr), 32'(expAddr.pop_front()));
      end
      if (bus.fifo_wen) begin
        writes++;
        if (firstIdx < 0) firstIdx = idx;
        if (expWord.size() == 0) checkOutput("extraWrite", 1, 0);
        else begin
          isPad = expIsPad.pop_front();
          if (!isPad) dataWritten++;
          checkOutput("fifoWord", 32'(bus.fifo_din), 32'(expWord.pop_front()));
        end
      end
      checkOutput("bufferOverfill", 32'(reads - dataWritten > 2), 0);
      if (done_o) begin
        finished = 1;
        doneIdx  = idx;
        checkOutput("busyAtDone", 32'(busy_o), 0);
      end else begin
        checkOutput("busyDuringRun", 32'(busy_o), 1);
      end
      @(posedge clk);
      idx++;
    end
    start_i = 1'b0;
    checkOutput("doneBeforeTimeout", 32'(finished), 1);
    checkOutput("writeCount", 32'(writes), 32'(v.expWrites));
    checkOutput("modelDrained", 32'(expWord.size() + expAddr.size()), 0);
    if (v.expFirst >= 0) checkOutput("firstWriteLatency", 32'(firstIdx), 32'(v.expFirst));
    if (v.expDone >= 0)  checkOutput("doneCycle", 32'(doneIdx), 32'(v.expDone));
    bus.fifo_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("quietAfterDone", 32'({done_o, busy_o, bus.fifo_wen, bus.mem_ren}), 0);
      @(posedge clk);
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput(name, 32'({bus.mem_ren, bus.mem_addr, bus.fifo_wen, bus.fifo_din, busy_o, done_o}), 0);
  endtask

  task automatic resetMidTransfer(input vec_t v);
    int writes, n;
    @(negedge clk);
    base_addr_i = 8'(v.base); row_len_i = 6'(v.len); row_count_i = 6'(v.cnt);
    row_stride_i = 8'(v.stride); pad_i = 2'(v.pad); start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    writes = 0; n = 0;
    while (writes < 5 && n < 100) begin
      #1;
      if (bus.fifo_wen) writes++;
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reachedFifthWrite", 32'(writes), 5);
    rst = 1'b1;
    @(posedge clk);
    #1 checkResetState("resetMidTransfer");
    rst = 1'b0;
    @(posedge clk);
    #1 checkResetState("idleAfterReset");
    applyStimulus(v);
  endtask

  initial begin
    vec_t v, basic;
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; row_len_i = '0; row_count_i = '0;
    row_stride_i = '0; pad_i = '0; bus.fifo_ready = 1'b1;
    for (int i = 0; i < 256; i++) memArr[i] = 10'(i + 1);

    //         base len cnt str pad mode writes first done busyStart
    vecs.push_back('{  0,  7,  2,  7, 0, 0, 14,  2, 16, -1});
    vecs.push_back('{  0,  7,  2,  7, 0, 1, 14, -1, -1, -1});
    vecs.push_back('{  0,  1,  3,  1, 0, 0,  3,  2,  5, -1});
    vecs.push_back('{  0,  0,  3,  1, 0, 0,  0, -1,  1, -1});
    vecs.push_back('{  5,  5,  0,  1, 0, 0,  0, -1,  1, -1});
    vecs.push_back('{250,  4,  2, 10, 0, 0,  8,  2, 10, -1});
    vecs.push_back('{  0,  7,  2,  7, 0, 0, 14,  2, 16,  4});
`ifdef IFMAP_WRITER_ZERO_PAD_EN
    vecs.push_back('{  4,  3,  1,  1, 1, 0,  5,  1, -1, -1});
    vecs.push_back('{ 20,  2,  2,  9, 2, 1, 12,  1, -1, -1});
`endif
    for (int i = 0; i < 6; i++) begin
      v.base = $urandom_range(0, 255); v.len = $urandom_range(1, 9);
      v.cnt = $urandom_range(1, 4);    v.stride = $urandom_range(0, 255);
`ifdef IFMAP_WRITER_ZERO_PAD_EN
      v.pad = $urandom_range(0, 3);
`else
      v.pad = 0;
`endif
      v.readyMode = 2; v.expWrites = v.cnt * (v.len + 2 * v.pad);
      v.expFirst = -1; v.expDone = -1; v.busyStartAt = -1;
      vecs.push_back(v);
    end

    repeat (2) @(posedge clk);
    #1 checkResetState("resetState");
    rst = 1'b0;
    @(posedge clk);

    foreach (vecs[i]) begin
      $display("[TB] job %0d: base=%0d len=%0d cnt=%0d stride=%0d pad=%0d mode=%0d", i,
               vecs[i].base, vecs[i].len, vecs[i].cnt, vecs[i].stride, vecs[i].pad, vecs[i].readyMode);
      applyStimulus(vecs[i]);
    end

    basic = vecs[0];
    $display("[TB] reset in the middle of the basic job, then replay");
    resetMidTransfer(basic);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
